// File: rtl/apb_master_arbiter.sv
// APB master shared by the instruction-fetch and load/store ports. It arbitrates round-robin,
// sequences SETUP/ACCESS, returns the response to the winner, and bounds wait states.
module apb_master_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  pclk,
  input  logic                  rst,
  // fetch port
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_done,
  output logic                  if_err,
  // load/store port
  input  logic                  ls_req,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  input  logic                  ls_write,
  input  logic [3:0]            ls_stb,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  ls_done,
  output logic                  ls_err,
  // APB
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  output logic                  pwrite,
  output logic [3:0]            pstb,
  output logic                  psel,
  output logic                  penable,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  perr
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW:0] TimeoutVal = (CntW + 1)'(TIMEOUT);
  localparam logic [CntW:0] CntOne = 1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e                state_q, state_d;
  logic                  gnt_ls_q, gnt_ls_d;  // current grant, doubles as last_grant
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic                  pwrite_q, pwrite_d;
  logic [3:0]            pstb_q, pstb_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic                  if_err_q, if_err_d;
  logic                  if_done_q, if_done_d;
  logic [DATA_WIDTH-1:0] ls_rdata_q, ls_rdata_d;
  logic                  ls_err_q, ls_err_d;
  logic                  ls_done_q, ls_done_d;

  logic timeout_hit;
  assign timeout_hit = (TIMEOUT != 0) && (({1'b0, cnt_q} + CntOne) == TimeoutVal);

  always_comb begin
    logic                  grant_ls;
    logic                  finish;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;
    grant_ls   = 1'b0;
    finish     = 1'b0;
    rsp_data   = '0;
    rsp_err    = 1'b0;
    state_d    = state_q;
    gnt_ls_d   = gnt_ls_q;
    cnt_d      = cnt_q;
    paddr_d    = paddr_q;
    pdata_d    = pdata_q;
    pwrite_d   = pwrite_q;
    pstb_d     = pstb_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    if_rdata_d = if_rdata_q;
    if_err_d   = if_err_q;
    if_done_d  = 1'b0;
    ls_rdata_d = ls_rdata_q;
    ls_err_d   = ls_err_q;
    ls_done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (if_req || ls_req) begin
          // On a tie the port that did not win last time goes first.
          grant_ls  = ls_req && (!if_req || !gnt_ls_q);
          gnt_ls_d  = grant_ls;
          paddr_d   = grant_ls ? ls_addr : if_addr;
          pdata_d   = grant_ls ? ls_wdata : '0;
          pwrite_d  = grant_ls & ls_write;
          pstb_d    = grant_ls ? ls_stb : 4'b0000;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          cnt_d     = '0;
          state_d   = StSetup;
        end
      end
      StSetup: begin
        penable_d = 1'b1;
        state_d   = StAccess;
      end
      StAccess: begin
        if (pready) begin
          finish   = 1'b1;
          rsp_data = pwrite_q ? '0 : prdata;
          rsp_err  = perr;
        end else if (timeout_hit) begin
          finish   = 1'b1;
          rsp_data = '0;
          rsp_err  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
        if (finish) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = StResp;
          if (gnt_ls_q) begin
            ls_rdata_d = rsp_data;
            ls_err_d   = rsp_err;
            ls_done_d  = 1'b1;
          end else begin
            if_rdata_d = rsp_data;
            if_err_d   = rsp_err;
            if_done_d  = 1'b1;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      gnt_ls_q   <= 1'b0;
      cnt_q      <= '0;
      paddr_q    <= '0;
      pdata_q    <= '0;
      pwrite_q   <= 1'b0;
      pstb_q     <= 4'b0000;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      if_rdata_q <= '0;
      if_err_q   <= 1'b0;
      if_done_q  <= 1'b0;
      ls_rdata_q <= '0;
      ls_err_q   <= 1'b0;
      ls_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_ls_q   <= gnt_ls_d;
      cnt_q      <= cnt_d;
      paddr_q    <= paddr_d;
      pdata_q    <= pdata_d;
      pwrite_q   <= pwrite_d;
      pstb_q     <= pstb_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      if_rdata_q <= if_rdata_d;
      if_err_q   <= if_err_d;
      if_done_q  <= if_done_d;
      ls_rdata_q <= ls_rdata_d;
      ls_err_q   <= ls_err_d;
      ls_done_q  <= ls_done_d;
    end
  end

  assign paddr    = paddr_q;
  assign pdata    = pdata_q;
  assign pwrite   = pwrite_q;
  assign pstb     = pstb_q;
  assign psel     = psel_q;
  assign penable  = penable_q;
  assign if_rdata = if_rdata_q;
  assign if_err   = if_err_q;
  assign if_done  = if_done_q;
  assign ls_rdata = ls_rdata_q;
  assign ls_err   = ls_err_q;
  assign ls_done  = ls_done_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: directed transfers push expected responses,
// a forked monitor pops and compares on every done pulse.
module tb_apb_master_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          pclk = 1'b0;
  logic          rst;
  logic          if_req, ls_req, ls_write;
  logic [AW-1:0] if_addr, ls_addr, paddr;
  logic [DW-1:0] ls_wdata, if_rdata, ls_rdata, pdata, prdata;
  logic [3:0]    ls_stb, pstb;
  logic          if_done, if_err, ls_done, ls_err;
  logic          pwrite, psel, penable, pready, perr;

  apb_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_err(if_err),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_write(ls_write),
    .ls_stb(ls_stb), .ls_rdata(ls_rdata), .ls_done(ls_done), .ls_err(ls_err),
    .paddr(paddr), .pdata(pdata), .pwrite(pwrite), .pstb(pstb), .psel(psel),
    .penable(penable), .prdata(prdata), .pready(pready), .perr(perr)
  );

  always #5 pclk = ~pclk;

  int unsigned cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // APB slave: pready after slv_wait ACCESS cycles without ready
  int unsigned   slv_wait = 0, acc_cnt = 0, acc_total = 0;
  logic [DW-1:0] slv_rdata = '0;
  logic          slv_err = 1'b0;
  always @(negedge pclk) begin
    if (psel && penable) begin
      pready = (acc_cnt == slv_wait);
      perr   = slv_err && (acc_cnt == slv_wait);
      prdata = slv_rdata;
      acc_cnt++;
      acc_total++;
    end else begin
      pready  = 1'b0;
      perr    = 1'b0;
      acc_cnt = 0;
    end
  end

  int total = 0, bad = 0;
  logic [33:0] exp_q[$];  // {is_ls, err, rdata}
  logic          bus_chk_en = 1'b0;
  logic [AW-1:0] exp_paddr;
  logic [DW-1:0] exp_pdata;
  logic          exp_pwrite;
  logic [3:0]    exp_pstb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic [33:0] e, a;
    forever begin
      @(negedge pclk);
      if (!rst) begin
        if (bus_chk_en && psel) begin
          check("bus_paddr", paddr, exp_paddr);
          check("bus_pdata", pdata, exp_pdata);
          check("bus_pwrite", pwrite, exp_pwrite);
          check("bus_pstb", pstb, exp_pstb);
        end
        if (if_done || ls_done) begin
          check("done_bus_idle", {psel, penable}, 2'b00);
          check("done_onehot", if_done & ls_done, 1'b0);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL done_unexpected: got if_done=%b ls_done=%b expected no done",
                     if_done, ls_done);
          end else begin
            e = exp_q.pop_front();
            a = {ls_done, ls_done ? ls_err : if_err, ls_done ? ls_rdata : if_rdata};
            check("done_resp", a, e);
          end
        end
      end
    end
  endtask

  task automatic wait_done(input bit is_ls);
    bit got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge pclk);
      got = is_ls ? ls_done : if_done;
    end
    check("done_seen", got, 1'b1);
  endtask

  task automatic xfer(input bit is_ls, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic wr, input logic [3:0] stb, input logic [33:0] exp);
    exp_q.push_back(exp);
    if (is_ls) begin
      ls_addr = addr; ls_wdata = wdata; ls_write = wr; ls_stb = stb; ls_req = 1'b1;
    end else begin
      if_addr = addr; if_req = 1'b1;
    end
    wait_done(is_ls);
    if_req = 1'b0;
    ls_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    int unsigned a0;
    int          nd;
    int unsigned dc[4];
    bit          got;
    rst = 1'b1;
    if_req = 1'b0; ls_req = 1'b0; ls_write = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_stb = 4'b0000;
    fork
      monitor();
    join_none
    repeat (2) @(negedge pclk);
    check("rst_psel_pen", {psel, penable}, 2'b00);
    check("rst_pwrite", pwrite, 1'b0);
    check("rst_done", {if_done, ls_done}, 2'b00);
    check("rst_err", {if_err, ls_err}, 2'b00);
    check("rst_paddr", paddr, 0);
    check("rst_pdata_pstb", {pdata, pstb}, 0);
    check("rst_rdata", {if_rdata, ls_rdata}, 0);
    rst = 1'b0;

    // Zero-wait fetch with cycle-exact phase checks
    slv_wait = 0; slv_rdata = 32'hDEAD_BEEF; slv_err = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 32'hDEAD_BEEF});
    if_addr = 32'h8000_0000; if_req = 1'b1;
    @(negedge pclk);
    check("t1_setup", {psel, penable}, 2'b10);
    check("t1_paddr", paddr, 32'h8000_0000);
    check("t1_pwrite", pwrite, 1'b0);
    @(negedge pclk);
    check("t1_access", {psel, penable}, 2'b11);
    @(negedge pclk);
    check("t1_done", if_done, 1'b1);
    if_req = 1'b0;
    @(negedge pclk);

    // Round robin from reset: ls first, then alternate every 4 cycles
    rst = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
    slv_rdata = 32'h1111_2222;
    if_addr = 32'h3000_0000; ls_addr = 32'h2000_0000; ls_write = 1'b0;
    ls_wdata = '0; ls_stb = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({1'b1, 1'b0, 32'h1111_2222});
      exp_q.push_back({1'b0, 1'b0, 32'h1111_2222});
    end
    if_req = 1'b1; ls_req = 1'b1;
    nd = 0;
    for (int n = 0; n < 40 && nd < 4; n++) begin
      @(negedge pclk);
      if (if_done || ls_done) begin
        dc[nd] = cyc;
        nd++;
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
    check("rr_count", nd, 4);
    for (int i = 1; i < 4; i++) check("rr_gap", dc[i] - dc[i-1], 4);

    // Store with 3 wait states: bus stable, rdata forced to 0, pready beats timeout
    exp_paddr = 32'h1000_0000; exp_pdata = 32'h41; exp_pwrite = 1'b1; exp_pstb = 4'b0001;
    bus_chk_en = 1'b1;
    slv_wait = 3; slv_rdata = 32'hCAFE_F00D; slv_err = 1'b0;
    a0 = acc_total;
    xfer(1'b1, 32'h1000_0000, 32'h41, 1'b1, 4'b0001, {1'b1, 1'b0, 32'h0});
    bus_chk_en = 1'b0;
    check("st_access_cycles", acc_total - a0, 4);

    // Load error, then a clean load clears ls_err
    slv_wait = 0; slv_rdata = 32'h1234_5678; slv_err = 1'b1;
    xfer(1'b1, 32'h1000_0004, '0, 1'b0, 4'b0000, {1'b1, 1'b1, 32'h1234_5678});
    slv_err = 1'b0; slv_rdata = 32'h0BAD_F00D;
    xfer(1'b1, 32'h1000_0008, '0, 1'b0, 4'b0000, {1'b1, 1'b0, 32'h0BAD_F00D});

    // Fetch timeout after 4 ACCESS cycles
    slv_wait = 1000; slv_rdata = 32'hFFFF_FFFF;
    a0 = acc_total;
    xfer(1'b0, 32'h8000_0010, '0, 1'b0, 4'b0000, {1'b0, 1'b1, 32'h0});
    check("to_access_cycles", acc_total - a0, 4);

    // Reset during ACCESS: async clear, no done pulse, then normal transfer
    if_addr = 32'h8000_0020; if_req = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge pclk);
      got = psel && penable;
    end
    check("rst_reach_access", got, 1'b1);
    @(posedge pclk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_bus", {psel, penable}, 2'b00);
    check("rst_async_paddr", paddr, 0);
    check("rst_async_done", {if_done, ls_done}, 2'b00);
    if_req = 1'b0;
    repeat (2) @(negedge pclk);
    rst = 1'b0;
    repeat (4) @(negedge pclk);
    check("rst_idle", psel, 1'b0);
    slv_wait = 1; slv_rdata = 32'h600D_CAFE;
    xfer(1'b0, 32'h8000_0020, '0, 1'b0, 4'b0000, {1'b0, 1'b0, 32'h600D_CAFE});

    repeat (3) @(negedge pclk);
    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Shares the single system APB bus between the instruction-fetch port and the load/store port of the core.
- Arbitrates between the two requesters and sequences the APB SETUP/ACCESS phases toward the address decoder.
- Returns read data, completion and error to the granted requester.
- Bounds every transfer with a wait-state timeout so a missing pready cannot hang the core.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
TIMEOUT, 255, maximum ACCESS cycles without pready before forced error; 0 disables timeout

Ports:
pclk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous active-high reset
if_req  in  1  fetch request (read only); held high until if_done
if_addr  in  ADDR_WIDTH  fetch address
if_rdata  out  DATA_WIDTH  fetch read data; valid while if_done=1
if_done  out  1  one-cycle completion pulse for fetch
if_err  out  1  fetch error; valid while if_done=1
ls_req  in  1  load/store request; held high until ls_done
ls_addr  in  ADDR_WIDTH  load/store address
ls_wdata  in  DATA_WIDTH  store data
ls_write  in  1  1=store, 0=load
ls_stb  in  4  byte strobes for stores
ls_rdata  out  DATA_WIDTH  load data; valid while ls_done=1
ls_done  out  1  one-cycle completion pulse for load/store
ls_err  out  1  load/store error; valid while ls_done=1
paddr  out  ADDR_WIDTH  APB address
pdata  out  DATA_WIDTH  APB write data
pwrite  out  1  APB write
pstb  out  4  APB strobes
psel  out  1  APB select
penable  out  1  APB enable
prdata  in  DATA_WIDTH  APB read data
pready  in  1  APB ready
perr  in  1  APB error

Behaviour:
- Reset: state=IDLE; psel, penable, pwrite, if_done, ls_done, if_err, ls_err = 0; paddr, pdata, pstb, if_rdata, ls_rdata = 0; last_grant = fetch.
- FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE. All outputs are registered.
- IDLE:
  - No req: remain in IDLE.
  - Exactly one req: grant that requester.
  - Both req: grant the requester that is not last_grant (round-robin). After reset, load/store wins the first tie.
  - On grant: latch paddr, plus pdata/pwrite/pstb for load/store. A fetch drives pwrite=0, pstb=0, pdata=0. Go to SETUP and update last_grant.
- SETUP: psel=1, penable=0 for exactly one cycle, then ACCESS.
- ACCESS:
  - psel=1, penable=1; wait counter increments each cycle.
  - pready=1: capture prdata (loads/fetches only; stores return rdata=0) and perr into the granted requester's rdata/err. Go to RESP.
  - TIMEOUT!=0 and counter reaches TIMEOUT with pready=0: rdata=0, err=1, go to RESP.
  - pready takes precedence over timeout on the same cycle.
- RESP: psel=0, penable=0; granted requester's done=1 for this cycle only. Go to IDLE.
- Requester protocol:
  - req, addr, wdata, write and stb are sampled only in IDLE and must stay stable until done.
  - A requester may drop req in the done cycle or hold it for a new transfer, which is sampled the following IDLE cycle.
  - Minimum 4 cycles per zero-wait transfer.
- Bus protocol:
  - paddr, pdata, pwrite and pstb stay stable from SETUP through the end of ACCESS.
  - paddr is held after the transfer until the next grant, keeping the decoder select stable.
- rdata/err of the non-granted requester are unchanged; its done stays 0.
- A req dropped while not granted is simply not served; no state is kept.
- Reset asserted mid-transfer: all outputs clear immediately, FSM returns to IDLE, and no done pulse is generated.

Test Plan:
- if_req=1, if_addr=0x80000000, pready=1 in first ACCESS cycle, prdata=0xDEADBEEF -> SETUP at cycle 1, ACCESS at 2, if_done=1 at 3 with if_rdata=0xDEADBEEF, if_err=0.
- if_req and ls_req both held high continuously after reset -> grants alternate ls, if, ls, if. Each done arrives 4 cycles apart with no bus overlap.
- ls_write=1, ls_addr=0x10000000, ls_wdata=0x41, ls_stb=0001, pready low for 3 ACCESS cycles -> pwrite/paddr/pdata/pstb stable for all 4 ACCESS cycles; ls_done after pready; ls_rdata=0.
- pready=1 with perr=1 on a load -> ls_err=1 with ls_done; the next transfer has ls_err=0.
- TIMEOUT=4, pready held 0 -> psel/penable drop after 4 ACCESS cycles; if_done=1, if_err=1, if_rdata=0.
- rst pulsed during ACCESS -> psel=penable=0 asynchronously, no done pulse; after release, a new request completes normally.
